nes_controller_responder: RTL and testbench

Controller-side end of the NES serial pad protocol: it responds to the console/receiver's latch and clock by shifting out a parallel button word on the data line, emulating a 4021-based pad. It sits between the Tiny Tapeout input pins (or an FPGA test rig) and the design's NES receiver. It lets the receiver and the game logic be exercised end-to-end without a physical controller. All protocol pins are asynchronous to `clk` and are synchronised internally.

---
 rtl/nes_pkg.sv | 57 +++++
 rtl/nes_pin_sync.sv | 44 ++++
 rtl/nes_controller_responder.sv | 135 +++++++++++++
 tb/tb_nes_controller_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES/SNES pad responder.
//   - FRAME_BITS_NES / FRAME_BITS_SNES : frame lengths of the two pad types
//   - FRAME_BITS                       : active frame length for this build
//   - LOAD_MASK                        : bits of buttons_in captured at load
//   - BTN_*                            : bit positions of each button
//   - state_t                          : responder FSM state encoding
// Configuration macro: NES_RESPONDER_SNES_EN (16-bit SNES frame when defined).
// -----------------------------------------------------------------------------
package nes_pkg;

   localparam int FRAME_BITS_NES  = 8;
   localparam int FRAME_BITS_SNES = 16;

`ifdef NES_RESPONDER_SNES_EN
   localparam int FRAME_BITS = FRAME_BITS_SNES;

   // Bits [15:12] are forced to 0 at load so they shift out as 1: the SNES
   // controller ID nibble.
   localparam logic [FRAME_BITS-1:0] LOAD_MASK = 16'h0FFF;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;
`else
   localparam int FRAME_BITS = FRAME_BITS_NES;

   localparam logic [FRAME_BITS-1:0] LOAD_MASK = 8'hFF;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      EMPTY = 2'd3
   } state_t;

endpackage

// File: rtl/nes_pin_sync.sv
// -----------------------------------------------------------------------------
// nes_pin_sync
// Synchroniser plus edge-strobe generator for one asynchronous protocol pin.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset (flushes chain and strobes to 0)
//   pin   in  asynchronous pin
//   rise  out 1-cycle strobe, SYNC_STAGES+1 cycles after a 0->1 pin edge
//   fall  out 1-cycle strobe, SYNC_STAGES+1 cycles after a 1->0 pin edge
// Parameter SYNC_STAGES (>= 2): flops in the synchroniser chain.
// -----------------------------------------------------------------------------
module nes_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= sync_out;
         // Strobes are registered so no downstream logic sees the chain
         // output combinationally.
         rise   <= sync_out & ~prev_q;
         fall   <= ~sync_out & prev_q;
      end
   end

endmodule

// File: rtl/nes_controller_responder.sv
// -----------------------------------------------------------------------------
// nes_controller_responder
// Controller-side end of the NES serial pad protocol, emulating a 4021 shift
// register: latch captures buttons_in, each nes_clk rise shifts the next bit
// out on nes_data (active-low).
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   buttons_in in   [FRAME_BITS] button states, 1 = pressed
//   nes_latch  in   asynchronous latch from the receiver
//   nes_clk    in   asynchronous shift clock from the receiver
//   nes_data   out  serial data, 0 = pressed, registered
//   frame_done out  1-cycle pulse when the last frame bit is consumed
//   bit_index  out  [5] index of the bit currently on nes_data
// Parameter SYNC_STAGES (>= 2): synchroniser depth on each protocol pin.
// Configuration macro: NES_RESPONDER_SNES_EN selects the 16-bit SNES frame
// (via nes_pkg::FRAME_BITS); undefined gives the 8-bit NES frame.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, line high, shift clocks ignored
// LOAD  | latch high, parallel mode: shreg and nes_data follow buttons_in
// SHIFT | latch low, each clk_rise advances one bit
// EMPTY | frame consumed, line held low (serial-in tied to 0)
// -----------------------------------------------------------------------------
module nes_controller_responder
   import nes_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FRAME_BITS-1:0] buttons_in,
   input  logic                  nes_latch,
   input  logic                  nes_clk,
   output logic                  nes_data,
   output logic                  frame_done,
   output logic [4:0]            bit_index
);

   localparam int         IDXW     = $clog2(FRAME_BITS);
   localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);
   localparam logic [4:0] END_IDX  = 5'(FRAME_BITS);

   logic                  latch_rise;
   logic                  latch_fall;
   logic                  clk_rise;
   logic                  clk_fall;
   logic                  unused_clk_fall;

   state_t                state;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] load_word;
   logic [4:0]            next_idx;

   nes_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (nes_latch),
      .rise  (latch_rise),
      .fall  (latch_fall)
   );

   nes_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (nes_clk),
      .rise  (clk_rise),
      .fall  (clk_fall)
   );

   // The protocol only advances on nes_clk rising edges.
   assign unused_clk_fall = clk_fall;

   assign load_word = buttons_in & LOAD_MASK;
   assign next_idx  = bit_index + 5'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         nes_data   <= 1'b1;
         frame_done <= 1'b0;
         bit_index  <= 5'd0;
      end else begin
         frame_done <= 1'b0;
         // A latch rise restarts the frame from any state and swallows a
         // coincident clk_rise.
         if (latch_rise) begin
            state     <= LOAD;
            shreg     <= load_word;
            nes_data  <= ~buttons_in[0];
            bit_index <= 5'd0;
         end else begin
            case (state)
               IDLE: begin
                  nes_data  <= 1'b1;
                  bit_index <= 5'd0;
               end
               LOAD: begin
                  // Parallel mode is transparent up to and including the
                  // cycle the fall is seen; a coincident clk_rise is dropped.
                  shreg     <= load_word;
                  nes_data  <= ~buttons_in[0];
                  bit_index <= 5'd0;
                  if (latch_fall) begin
                     state <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (clk_rise) begin
                     if (bit_index == LAST_IDX) begin
                        bit_index  <= END_IDX;
                        nes_data   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= EMPTY;
                     end else begin
                        bit_index <= next_idx;
                        nes_data  <= ~shreg[next_idx[IDXW-1:0]];
                     end
                  end
               end
               EMPTY: begin
                  nes_data  <= 1'b0;
                  bit_index <= END_IDX;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nes_controller_responder.sv
module tb_nes_controller_responder;

`ifdef NES_RESPONDER_SNES_EN
   localparam int           FB    = 16;
   localparam logic [15:0]  MASK  = 16'h0FFF;
   localparam logic [15:0]  BASIC = 16'h0101;
`else
   localparam int           FB    = 8;
   localparam logic [7:0]   MASK  = 8'hFF;
   localparam logic [7:0]   BASIC = 8'h81;
`endif
   localparam int LAT    = 4;   // pin edge to output update at SYNC_STAGES=2
   localparam int SETTLE = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [FB-1:0] buttons_in;
   logic          nes_latch;
   logic          nes_clk;
   logic          nes_data;
   logic          frame_done;
   logic [4:0]    bit_index;

   int n_cmp = 0;
   int n_err = 0;
   int done_cycles = 0;

   // Reference model: 0 = idle, 1 = latch held, 2 = shifting / exhausted
   int            m_st;
   int            m_idx;
   int            m_done;
   logic [FB-1:0] m_word;

   nes_controller_responder #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .buttons_in (buttons_in),
      .nes_latch  (nes_latch),
      .nes_clk    (nes_clk),
      .nes_data   (nes_data),
      .frame_done (frame_done),
      .bit_index  (bit_index)
   );

   always #20 clk = ~clk;

   always @(posedge clk) begin
      if (frame_done === 1'b1) done_cycles++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_data();
      if (m_st == 0) return 1'b1;
      if (m_st == 1) return ~buttons_in[0];
      if (m_idx < FB) return ~m_word[m_idx];
      return 1'b0;
   endfunction

   function automatic logic [4:0] exp_idx();
      return (m_st == 2) ? 5'(m_idx) : 5'd0;
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_data"}, {31'd0, nes_data}, {31'd0, exp_data()});
      check({tag, "_idx"}, {27'd0, bit_index}, {27'd0, exp_idx()});
      check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
   endtask

   task automatic drive_latch(input logic v);
      if (v && !nes_latch) begin
         m_st = 1; m_idx = 0;
      end else if (!v && nes_latch && m_st == 1) begin
         m_st = 2; m_idx = 0; m_word = buttons_in & MASK;
      end
      nes_latch = v;
      step(SETTLE);
   endtask

   // One nes_clk pulse; checks the output is unchanged before LAT cycles and
   // updated exactly at LAT cycles.
   task automatic clk_pulse(input string tag);
      logic old_d;
      old_d = exp_data();
      nes_clk = 1'b1;
      step(LAT - 1);
      check({tag, "_early"}, {31'd0, nes_data}, {31'd0, old_d});
      step(1);
      if (m_st == 2 && m_idx < FB) begin
         m_idx++;
         if (m_idx == FB) m_done++;
      end
      check({tag, "_data"}, {31'd0, nes_data}, {31'd0, exp_data()});
      check({tag, "_idx"}, {27'd0, bit_index}, {27'd0, exp_idx()});
      step(SETTLE - LAT);
      nes_clk = 1'b0;
      step(SETTLE);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; nes_latch = 1'b0; nes_clk = 1'b0;
      step(3);
      m_st = 0; m_idx = 0;
      check_all("reset");
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      buttons_in = '0; nes_latch = 1'b0; nes_clk = 1'b0; rst_n = 1'b0;
      m_st = 0; m_idx = 0; m_done = 0; m_word = '0;

      do_reset();
      for (int i = 0; i < 3; i++) clk_pulse("idle_clk");
      check_all("idle");

      // Basic frame followed by exhaustion
      buttons_in = BASIC;
      drive_latch(1'b1); check_all("basic_latch_hi");
      drive_latch(1'b0); check_all("basic_latch_lo");
      for (int k = 0; k < FB + 2; k++) clk_pulse($sformatf("basic_%0d", k));
      check("exhaust_idx", {27'd0, bit_index}, FB);
      check("exhaust_data", {31'd0, nes_data}, 32'd0);
      check("exhaust_done_cnt", done_cycles, m_done);
      check("exhaust_model_done", m_done, 32'd1);

      // Restart mid-frame
      buttons_in = '0; buttons_in[1] = 1'b1;
      drive_latch(1'b1); drive_latch(1'b0);
      for (int k = 0; k < 3; k++) clk_pulse("restart_a");
      buttons_in = '0; buttons_in[2] = 1'b1;
      drive_latch(1'b1); drive_latch(1'b0);
      clk_pulse("restart_b0"); clk_pulse("restart_b1");
      check("restart_idx2", {27'd0, bit_index}, 32'd2);
      check("restart_bit2", {31'd0, nes_data}, 32'd0);

      // Freeze while latched, then ignore button changes after latch falls
      buttons_in = '0; buttons_in[0] = 1'b1; buttons_in[3] = 1'b1;
      drive_latch(1'b1);
      clk_pulse("frz_hi0"); clk_pulse("frz_hi1");
      check_all("frz_hi");
      buttons_in[0] = 1'b0; step(2);
      check_all("frz_transparent");
      drive_latch(1'b0);
      buttons_in = '1;
      for (int k = 0; k < 5; k++) clk_pulse("frz_shift");

      // Randomized frames with mid-frame button churn and resets
      for (int it = 0; it < 24; it++) begin
         int n;
         buttons_in = FB'($urandom);
         drive_latch(1'b1); check_all("rnd_hi");
         drive_latch(1'b0); check_all("rnd_lo");
         n = $urandom_range(0, FB + 2);
         for (int k = 0; k < n; k++) begin
            clk_pulse("rnd_clk");
            if ($urandom_range(0, 3) == 0) buttons_in = FB'($urandom);
         end
         check_all("rnd_end");
         if (it % 6 == 5) do_reset();
      end

      step(SETTLE);
      check("done_total", done_cycles, m_done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
